// File: rtl/hint_bit_unpack.sv
// rtl/hint_bit_unpack.sv - ML-DSA HintBitUnpack: rebuilds the K x 256 hint matrix from the W+K byte hint field
// Examines one byte per clock and rejects malformed encodings with h forced to zero.
module hint_bit_unpack #(
  parameter int K = 8,
  parameter int W = 75
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   startpin,
  input  logic [(W+K)*8-1:0]     y,
  output logic                   endpin,
  output logic [K-1:0][255:0]    h,
  output logic                   malformed
);

  localparam int             IW = $clog2(K + 1);
  localparam int             RW = (K > 1) ? $clog2(K) : 1;
  localparam logic [7:0]     W8 = 8'(W);
  localparam logic [IW-1:0]  KI = IW'(K);

  typedef enum logic [2:0] {IDLE, BOUND, SET, ZCHK, DONE} state_t;

  state_t          state, state_n;
  logic [7:0]      index, first, limit;
  logic [IW-1:0]   i;
  logic [RW-1:0]   row;
  logic [7:0]      ybyte [256];
  logic [7:0]      cur_b, prev_b, lim_b, lim_addr;

  logic clr, fail, ld_lim, ld_first, set_bit, inc_idx, inc_row, fin, rel;

  // Byte view of y padded to 256 entries so an 8-bit pointer always selects in range.
  for (genvar b = 0; b < 256; b++) begin : g_byte
    if (b < W + K) begin : g_in
      assign ybyte[b] = y[b*8 +: 8];
    end else begin : g_pad
      assign ybyte[b] = 8'h00;
    end
  end

  assign lim_addr = W8 + 8'(i);
  assign cur_b    = ybyte[index];
  assign prev_b   = ybyte[index - 8'd1];
  assign lim_b    = ybyte[lim_addr];
  assign row      = i[RW-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n  = state;
    clr      = 1'b0;
    fail     = 1'b0;
    ld_lim   = 1'b0;
    ld_first = 1'b0;
    set_bit  = 1'b0;
    inc_idx  = 1'b0;
    inc_row  = 1'b0;
    fin      = 1'b0;
    rel      = 1'b0;
    case (state)
      IDLE: begin
        if (startpin) begin
          clr     = 1'b1;
          state_n = BOUND;
        end
      end
      BOUND: begin
        if (i == KI) begin
          state_n = ZCHK;
        end else begin
          ld_lim = 1'b1;
          // The row limit is validated before it ever bounds the SET loop.
          if (lim_b < index || lim_b > W8) begin
            fail = 1'b1;
          end else begin
            ld_first = 1'b1;
            state_n  = SET;
          end
        end
      end
      SET: begin
        if (index < limit) begin
          if (index > first && prev_b >= cur_b) begin
            fail = 1'b1;
          end else begin
            set_bit = 1'b1;
            inc_idx = 1'b1;
          end
        end else begin
          inc_row = 1'b1;
          state_n = BOUND;
        end
      end
      ZCHK: begin
        if (index < W8) begin
          if (cur_b != 8'h00) fail = 1'b1;
          else                inc_idx = 1'b1;
        end else begin
          fin     = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (!startpin) begin
          rel     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (fail) state_n = DONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h         <= '0;
      endpin    <= 1'b0;
      malformed <= 1'b0;
      index     <= 8'd0;
      i         <= '0;
      first     <= 8'd0;
      limit     <= 8'd0;
    end else begin
      if (clr) begin
        h         <= '0;
        endpin    <= 1'b0;
        malformed <= 1'b0;
        index     <= 8'd0;
        i         <= '0;
      end
      if (ld_lim)   limit <= lim_b;
      if (ld_first) first <= index;
      if (set_bit)  h[row][cur_b] <= 1'b1;
      if (inc_idx)  index <= index + 8'd1;
      if (inc_row)  i <= i + 1'b1;
      if (fin)      endpin <= 1'b1;
      if (rel)      endpin <= 1'b0;
      if (fail) begin
        h         <= '0;
        malformed <= 1'b1;
        endpin    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hint_bit_unpack.sv
// tb/tb_hint_bit_unpack.sv - randomized and directed self-checking bench for hint_bit_unpack
module tb_hint_bit_unpack;

  localparam int K = 8;
  localparam int W = 75;
  localparam int N = W + K;
  localparam int VALID_LAT = 2*K + W + 2;

  logic                  clk;
  logic                  rst;
  logic                  startpin;
  logic [N*8-1:0]        y;
  logic                  endpin;
  logic [K-1:0][255:0]   h;
  logic                  malformed;

  int n_chk;
  int n_fail;

  logic [255:0] mh [K];
  int           m_lat;
  bit           m_mal;

  hint_bit_unpack #(.K(K), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .startpin  (startpin),
    .y         (y),
    .endpin    (endpin),
    .h         (h),
    .malformed (malformed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic setb(input int b, input int v);
    y[b*8 +: 8] = v[7:0];
  endtask

  function automatic int byteof(input int b);
    logic [7:0] v;
    v = y[b*8 +: 8];
    return int'(v);
  endfunction

  // Reference decode straight from the encoding rules; a fault's latency is the
  // number of bytes/row boundaries consumed up to and including the bad one.
  task automatic model();
    int idx, t, lim, fst;
    bit bad;
    for (int r = 0; r < K; r++) mh[r] = '0;
    idx = 0;
    t   = 0;
    bad = 0;
    for (int r = 0; r < K && !bad; r++) begin
      t++;
      lim = byteof(W + r);
      if (lim < idx || lim > W) begin
        bad = 1;
      end else begin
        fst = idx;
        while (idx < lim && !bad) begin
          t++;
          if (idx > fst && byteof(idx - 1) >= byteof(idx)) bad = 1;
          else begin
            mh[r][byteof(idx)] = 1'b1;
            idx++;
          end
        end
        if (!bad) t++;
      end
    end
    if (!bad) begin
      t++;
      while (idx < W && !bad) begin
        t++;
        if (byteof(idx) != 0) bad = 1;
        else idx++;
      end
    end
    if (bad) begin
      for (int r = 0; r < K; r++) mh[r] = '0;
      m_lat = t;
    end else begin
      m_lat = VALID_LAT;
    end
    m_mal = bad;
  endtask

  task automatic run_case(input string tag, input int hold);
    int  lat;
    bit  seen;
    model();
    @(negedge clk);
    startpin = 1'b1;
    @(posedge clk);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
      if (endpin) seen = 1;
    end
    chk({tag, "_lat"}, 256'(lat), 256'(m_lat));
    chk({tag, "_mal"}, 256'(malformed), 256'(m_mal));
    for (int r = 0; r < K; r++) chk($sformatf("%s_h%0d", tag, r), h[r], mh[r]);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      chk({tag, "_hold_end"}, 256'(endpin), 256'(1));
      chk({tag, "_hold_mal"}, 256'(malformed), 256'(m_mal));
      chk({tag, "_hold_h0"}, h[0], mh[0]);
    end
    @(negedge clk);
    startpin = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_release"}, 256'(endpin), 256'(0));
  endtask

  task automatic load_case2();
    y = '0;
    setb(0, 5);
    setb(1, 200);
    setb(2, 255);
    for (int b = W; b < W + K - 1; b++) setb(b, 2);
    setb(W + K - 1, 3);
  endtask

  task automatic gen_random();
    int lims [K];
    int tot, prev, pos, cnt, n, v, tmp;
    logic [255:0] sel;
    y   = '0;
    tot = $urandom_range(0, W);
    for (int r = 0; r < K - 1; r++) lims[r] = $urandom_range(0, tot);
    lims[K-1] = tot;
    for (int a = 0; a < K; a++)
      for (int b = 0; b < K - 1 - a; b++)
        if (lims[b] > lims[b+1]) begin
          tmp       = lims[b];
          lims[b]   = lims[b+1];
          lims[b+1] = tmp;
        end
    prev = 0;
    pos  = 0;
    for (int r = 0; r < K; r++) begin
      cnt = lims[r] - prev;
      sel = '0;
      n   = 0;
      while (n < cnt) begin
        v = $urandom_range(0, 255);
        if (!sel[v]) begin
          sel[v] = 1'b1;
          n++;
        end
      end
      for (int j = 0; j < 256; j++)
        if (sel[j]) begin
          setb(pos, j);
          pos++;
        end
      setb(W + r, lims[r]);
      prev = lims[r];
    end
    if ($urandom_range(0, 2) == 0) setb($urandom_range(0, N - 1), $urandom_range(0, 255));
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst      = 1'b0;
    startpin = 1'b0;
    y        = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_end", 256'(endpin), 256'(0));
    chk("rst_mal", 256'(malformed), 256'(0));
    chk("rst_h0", h[0], 256'(0));
    chk("rst_h7", h[K-1], 256'(0));
    @(negedge clk);
    rst = 1'b1;

    y = '0;
    run_case("zero", 0);

    load_case2();
    run_case("case2", 0);

    y = '0;
    for (int b = 0; b < W; b++) setb(b, b);
    for (int b = W; b < N; b++) setb(b, W);
    run_case("fullw", 0);

    y = '0; setb(0, 9); setb(1, 9); setb(W, 2);
    run_case("bad_rep", 0);
    y = '0; setb(W, 3); setb(W + 1, 2);
    run_case("bad_dec", 0);
    y = '0; setb(W, 76);
    run_case("bad_lim", 0);
    y = '0; setb(N - 1, 3); setb(10, 1);
    run_case("bad_pad", 0);

    // Reset in the middle of row 0, after h[0][5] has been written.
    load_case2();
    @(negedge clk);
    startpin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_h0_set", 256'(h[0][5]), 256'(1));
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_end", 256'(endpin), 256'(0));
    chk("mid_rst_mal", 256'(malformed), 256'(0));
    chk("mid_rst_h0", h[0], 256'(0));
    @(negedge clk);
    startpin = 1'b0;
    rst      = 1'b1;
    run_case("case2_again", 0);

    y = '0; setb(W, 76);
    run_case("hold_bad", 6);
    load_case2();
    run_case("hold_ok", 6);

    for (int c = 0; c < 40; c++) begin
      gen_random();
      run_case($sformatf("rnd%0d", c), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
